evm_ballot_unit: RTL

//   Voter-side ballot unit; the producing end of the vote interface consumed by evm.

---
 rtl/evm_pkg.sv | 33 +++
 rtl/evm_key_debounce.sv | 44 ++++
 rtl/evm_ballot_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/evm_pkg.sv
// rtl/evm_pkg.sv - ballot unit states, candidate codes and key helpers shared with evm
package evm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DEBOUNCE,
    ST_SEND,
    ST_WAIT_REL
  } state_e;

  localparam logic [1:0] C0 = 2'd0;
  localparam logic [1:0] C1 = 2'd1;
  localparam logic [1:0] C2 = 2'd2;
  localparam logic [1:0] C3 = 2'd3;

  // Only meaningful for a one-hot key; anything else maps to C0.
  function automatic logic [1:0] encode_key(input logic [3:0] key);
    logic [1:0] code;
    case (key)
      4'b0010: code = C1;
      4'b0100: code = C2;
      4'b1000: code = C3;
      default: code = C0;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] key_count(input logic [3:0] key);
    return {2'b00, key[0]} + {2'b00, key[1]} + {2'b00, key[2]} + {2'b00, key[3]};
  endfunction

endpackage

// File: rtl/evm_key_debounce.sv
// rtl/evm_key_debounce.sv - 2-FF key synchronizer with stability counter
module evm_key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_raw,
  output logic [3:0] key_sync,
  output logic       stable
);

  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [19:0] cnt_q, cnt_d;

  // The counter clears on the same edge the synced key changes, so it always
  // measures how long the currently visible key pattern has been steady.
  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    if (sync1_q != sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q < DEBOUNCE_CYCLES) begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_sync = sync2_q;
  assign stable   = (cnt_q == DEBOUNCE_CYCLES);

endmodule

// File: rtl/evm_ballot_unit.sv
// rtl/evm_ballot_unit.sv - voter ballot unit: arm, debounce, present vote, count ballots
module evm_ballot_unit
  import evm_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ISSUE,
  input  logic [3:0]  KEY,
  input  logic        VOTE_ACK,
  output logic [1:0]  S,
  output logic        VOTE_VALID,
  output logic        READY,
  output logic        BUSY,
  output logic        MULTI_KEY,
  output logic        TIMEOUT,
  output logic [31:0] BALLOT_COUNT
);

  logic [3:0] key_sync;
  logic       key_stable;

  evm_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (CLK),
    .rst     (RESET),
    .key_raw (KEY),
    .key_sync(key_sync),
    .stable  (key_stable)
  );

  state_e      state_q, state_d;
  logic [3:0]  key_q, key_d;
  logic        seen_release_q, seen_release_d;
  logic [31:0] timer_q, timer_d;
  logic [1:0]  s_q, s_d;
  logic        vote_valid_q, vote_valid_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        timeout_q, timeout_d;
  logic [31:0] ballot_count_q, ballot_count_d;

  logic timer_expired;
  logic key_one;
  logic keys_zero;

  assign timer_expired = (TIMEOUT_CYCLES != 32'd0) && (timer_q == TIMEOUT_CYCLES - 32'd1);
  assign key_one       = (key_count(key_sync) == 3'd1);
  assign keys_zero     = (key_sync == 4'b0000);

  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    seen_release_d = seen_release_q;
    timer_d        = timer_q;
    s_d            = s_q;
    timeout_d      = 1'b0;
    ballot_count_d = ballot_count_q;

    case (state_q)
      ST_IDLE: begin
        if (ISSUE) begin
          state_d        = ST_ARMED;
          timer_d        = '0;
          seen_release_d = 1'b0;
        end
      end
      ST_ARMED: begin
        if (timer_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d        = timer_q + 32'd1;
          seen_release_d = seen_release_q | keys_zero;
          // A key held from before ISSUE never votes until it has been let go.
          if (seen_release_q && key_one) begin
            state_d = ST_DEBOUNCE;
            key_d   = key_sync;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (timer_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
          if (key_sync != key_q) begin
            state_d = ST_ARMED;
          end else if (key_stable) begin
            state_d = ST_SEND;
            s_d     = encode_key(key_q);
          end
        end
      end
      ST_SEND: begin
        if (VOTE_ACK) begin
          state_d        = ST_WAIT_REL;
          ballot_count_d = ballot_count_q + 32'd1;
        end
      end
      ST_WAIT_REL: begin
        if (keys_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    vote_valid_d = (state_d == ST_SEND);
    ready_d      = (state_d == ST_ARMED) || (state_d == ST_DEBOUNCE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      key_q          <= '0;
      seen_release_q <= 1'b0;
      timer_q        <= '0;
      s_q            <= '0;
      vote_valid_q   <= 1'b0;
      ready_q        <= 1'b0;
      busy_q         <= 1'b0;
      timeout_q      <= 1'b0;
      ballot_count_q <= '0;
    end else begin
      state_q        <= state_d;
      key_q          <= key_d;
      seen_release_q <= seen_release_d;
      timer_q        <= timer_d;
      s_q            <= s_d;
      vote_valid_q   <= vote_valid_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
      timeout_q      <= timeout_d;
      ballot_count_q <= ballot_count_d;
    end
  end

  assign S            = s_q;
  assign VOTE_VALID   = vote_valid_q;
  assign READY        = ready_q;
  assign BUSY         = busy_q;
  assign TIMEOUT      = timeout_q;
  assign BALLOT_COUNT = ballot_count_q;
  assign MULTI_KEY    = (key_count(key_sync) > 3'd1);

endmodule
